// File: rtl/tdm_demux_8ch.sv
// TDM receive demultiplexer: de-interleaves an 8-slot serial stream into
// eight registered channel outputs, updated atomically once per frame.
module tdm_demux_8ch #(
    parameter int W        = 1,
    parameter bit FLYWHEEL = 1'b1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         EN,
    input  logic [W-1:0] Q,
    input  logic         SYNC,
    output logic [2:0]   A,
    output logic [W-1:0] D0,
    output logic [W-1:0] D1,
    output logic [W-1:0] D2,
    output logic [W-1:0] D3,
    output logic [W-1:0] D4,
    output logic [W-1:0] D5,
    output logic [W-1:0] D6,
    output logic [W-1:0] D7,
    output logic         FRAME_VALID,
    output logic         SYNC_ERR
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_d;
    logic [2:0]        a_d;
    logic [7:0][W-1:0] shadow, dout;
    logic              shadow_we, dout_we, fv_d, se_d;
    logic [2:0]        shadow_idx;

    always_comb begin
        state_d    = state;
        a_d        = A;
        shadow_we  = 1'b0;
        shadow_idx = A;
        dout_we    = 1'b0;
        fv_d       = 1'b0;
        se_d       = 1'b0;
        if (EN) begin
            state_d = IDLE;
            a_d     = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    a_d = 3'd0;
                    if (SYNC) begin
                        shadow_we  = 1'b1;
                        shadow_idx = 3'd0;
                        a_d        = 3'd1;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (SYNC) begin
                        // SYNC anywhere but slot 0 restarts the frame, dropping the partial one
                        se_d       = (A != 3'd0);
                        shadow_we  = 1'b1;
                        shadow_idx = 3'd0;
                        a_d        = 3'd1;
                    end else if (A == 3'd0) begin
                        if (FLYWHEEL) begin
                            shadow_we  = 1'b1;
                            shadow_idx = 3'd0;
                            a_d        = 3'd1;
                        end else begin
                            se_d    = 1'b1;
                            state_d = IDLE;
                            a_d     = 3'd0;
                        end
                    end else if (A == 3'd7) begin
                        dout_we = 1'b1;
                        fv_d    = 1'b1;
                        a_d     = 3'd0;
                    end else begin
                        shadow_we = 1'b1;
                        a_d       = A + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            A           <= 3'd0;
            shadow      <= '0;
            dout        <= '0;
            FRAME_VALID <= 1'b0;
            SYNC_ERR    <= 1'b0;
        end else begin
            state       <= state_d;
            A           <= a_d;
            FRAME_VALID <= fv_d;
            SYNC_ERR    <= se_d;
            if (shadow_we)
                shadow[shadow_idx] <= Q;
            // Slot 7 bypasses the shadow so the frame lands one cycle after its last sample
            if (dout_we)
                dout <= {Q, shadow[6:0]};
        end
    end

    assign D0 = dout[0];
    assign D1 = dout[1];
    assign D2 = dout[2];
    assign D3 = dout[3];
    assign D4 = dout[4];
    assign D5 = dout[5];
    assign D6 = dout[6];
    assign D7 = dout[7];

endmodule

// File: doc/tdm_demux_8ch.md
Name: tdm_demux_8ch

Overview:
- Receive-side counterpart of the 8-to-1 multiplexer.
- Takes the time-division serial stream produced by the mux (one channel sample per clock, frame marked by SYNC) and de-interleaves it into 8 registered channel outputs D0..D7.
- Tracks the current slot on A, double-buffers a frame so D0..D7 change atomically, and flags frame completion and sync errors.

Parameters:
- W, 1, width in bits of each channel sample (Q and each Dn).
- FLYWHEEL, 1, 1 = keep counting frames when SYNC is absent at slot 0; 0 = drop to IDLE when SYNC is missing at the expected frame start.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge
- EN  input  1  active-low enable (0 = run, 1 = disabled)
- Q  input  W  serial TDM sample stream from the multiplexer
- SYNC  input  1  high for one cycle alongside the slot-0 sample of a frame
- A  output  3  current slot index being captured
- D0..D7  output  W each  registered de-interleaved channel samples
- FRAME_VALID  output  1  one-cycle pulse, D0..D7 just updated with a complete frame
- SYNC_ERR  output  1  one-cycle pulse, SYNC seen at a slot other than 0, or missing at slot 0 with FLYWHEEL=0

Behaviour:
- Reset (RST_N=0 at edge): state=IDLE, A=0, D0..D7=0, shadow=0, FRAME_VALID=0, SYNC_ERR=0. Reset takes priority over all other inputs and over any frame in progress.
- States: IDLE, RUN.
- IDLE:
  - A holds 0.
  - When EN=0 and SYNC=1: store Q into shadow[0], set A=1, go to RUN.
  - SYNC=0: stay in IDLE, no capture.
- RUN, EN=0, SYNC=0:
  - shadow[A] <= Q.
  - A <= A+1, wrapping from 7 to 0.
- RUN, slot 7:
  - On the edge that samples slot 7, D0..D6 load from shadow[0..6] and D7 loads Q directly (all updated in the same edge).
  - FRAME_VALID=1 for exactly the next cycle.
  - Latency: the slot-n sample appears on Dn 8-n cycles after it is presented.
- RUN, next frame start (A wrapped to 0):
  - SYNC=1 at A=0: normal; capture into shadow[0], A=1.
  - SYNC=0 at A=0 with FLYWHEEL=1: treated as slot 0 anyway.
  - SYNC=0 at A=0 with FLYWHEEL=0: SYNC_ERR pulse, go to IDLE, A=0.
- RUN, SYNC=1 at A≠0 (resync):
  - Partial frame discarded, no FRAME_VALID.
  - Q captured as shadow[0], A=1.
  - SYNC_ERR=1 for one cycle.
- EN=1 in any state:
  - Next edge: state=IDLE, A=0, shadow contents ignored, no FRAME_VALID.
  - D0..D7 hold their last values, not cleared.
- EN returning to 0: capture resumes only at the next SYNC.
- Simultaneous events:
  - EN=1 wins over SYNC.
  - RST_N=0 wins over everything.
  - When a resync SYNC arrives on the slot-7 edge, the resync wins: no D update, SYNC_ERR=1.
- FRAME_VALID and SYNC_ERR are never high in the same cycle.

Test Plan:
- Reset then EN=0; SYNC=1 with slot 0, then Q = 0,1,0,1,0,1,0,1 over slots 0..7 -> one cycle after the slot-7 edge, D7..D0 = 1,0,1,0,1,0,1,0, FRAME_VALID=1 for 1 cycle, A=0.
- Back-to-back frames with SYNC every 8 cycles, second frame Q = 1,0,0,1,1,0,1,0 -> D7..D0 = 0,1,0,1,1,0,0,1. FRAME_VALID pulses every 8 cycles; D0..D7 stay stable between pulses.
- SYNC reasserted at A=3 mid-frame -> SYNC_ERR=1 for 1 cycle, A=1 next cycle, no FRAME_VALID for the partial frame, next full frame decodes correctly.
- EN=1 at A=5 for 10 cycles, Q toggling -> A=0 and D0..D7 unchanged throughout, FRAME_VALID=0. After EN=0, no capture until SYNC; then a normal frame decodes.
- FLYWHEEL=0, SYNC omitted at the frame boundary -> SYNC_ERR pulse, state IDLE, A=0. FLYWHEEL=1, same stimulus -> next frame decoded, FRAME_VALID pulses, SYNC_ERR=0.
- RST_N=0 for 1 cycle at A=6 -> next cycle A=0, D0..D7=0, FRAME_VALID=0, SYNC_ERR=0.
